// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   state_e : FSM encoding (IDLE waits for a word, SHIFT emits bits).
//   cnt_w() : width of the per-word bit counter for a given word width.
//   bit_sel : serial tap of the shift register for the chosen bit order.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Largest supported word; bit_sel works on a register zero-extended to this.
  localparam int MAX_WIDTH = 32;

  // Counter width for the default 4-bit word; modules derive their own
  // value from WIDTH with cnt_w().
  localparam int CNT_W = $clog2(4);

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // The bit that leaves the shift register this cycle: the top bit when
  // sending MSB first, otherwise bit 0.
  function automatic logic bit_sel(input logic [MAX_WIDTH-1:0] shreg,
                                   input int                   width,
                                   input logic                 msb_first);
    if (msb_first) begin
      return shreg[width-1];
    end
    return shreg[0];
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit position counter for one serialized word.
//   clk, rst : clock and asynchronous active-high reset.
//   clear    : force the count to 0 (start of a new word / return to idle).
//   enable   : advance by one; saturates at WIDTH-1 so it never wraps.
//   count    : current bit index within the word.
//   at_last  : count has reached WIDTH-1.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  output logic [cnt_w(WIDTH)-1:0] count,
  output logic                    at_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST_IDX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == LAST_IDX);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and framing strobes.
//   clk, rst  : clock and asynchronous active-high reset.
//   par_in    : WIDTH-bit word, captured when in_valid && in_ready.
//   in_valid  : par_in holds a word to send.
//   in_ready  : word can be captured this edge (idle, or on the last bit of
//               the current word so words run back-to-back without a gap).
//   d         : serial data bit (MSB or LSB first per MSB_FIRST).
//   d_valid   : d carries a payload bit.
//   first     : first bit of a word.
//   last      : final bit of a word.
//   busy      : a word is being shifted out.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             d_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CW-1:0]    cnt;
  logic             cnt_at_last;
  logic             shifting;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (cnt),
    .at_last (cnt_at_last)
  );

  // Vacated position is zero-filled so an idle or drained register reads 0.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  assign shifting = (state_q == SHIFT);
  assign first    = shifting && (cnt == '0);
  assign last     = shifting && cnt_at_last;
  assign busy     = shifting;
  assign d_valid  = shifting;
  assign d        = shifting && bit_sel(MAX_WIDTH'(shreg_q), WIDTH, MSB_FIRST);
  assign in_ready = (state_q == IDLE) || last;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          shreg_d   = par_in;
          cnt_clear = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_at_last) begin
          cnt_clear = 1'b1;
          if (in_valid) begin
            // Next word follows immediately on the following cycle.
            shreg_d = par_in;
          end else begin
            state_d = IDLE;
            shreg_d = '0;
          end
        end else begin
          shreg_d = shreg_shifted;
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        shreg_d   = '0;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk;
  logic       rst;

  logic [3:0] par_in;
  logic       in_valid;
  logic       in_ready;
  logic       d;
  logic       d_valid;
  logic       first;
  logic       last;
  logic       busy;

  logic [3:0] par_in_l;
  logic       in_valid_l;
  logic       in_ready_l;
  logic       d_l;
  logic       d_valid_l;
  logic       first_l;
  logic       last_l;
  logic       busy_l;

  logic [3:0] sipo_q;

  int checks_total;
  int checks_passed;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .par_in   (par_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .d_valid  (d_valid),
    .first    (first),
    .last     (last),
    .busy     (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
    .par_in   (par_in_l),
    .in_valid (in_valid_l),
    .in_ready (in_ready_l),
    .d        (d_l),
    .d_valid  (d_valid_l),
    .first    (first_l),
    .last     (last_l),
    .busy     (busy_l)
  );

  // Stand-in for the downstream 4-bit SIPO shift register.
  always @(posedge clk or posedge rst) begin
    if (rst) sipo_q <= 4'b0000;
    else if (d_valid) sipo_q <= {sipo_q[2:0], d};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for the next falling edge and compare every MSB-first output.
  task automatic step(input string tag, input logic ed, input logic ev,
                      input logic ef, input logic el, input logic er);
    @(negedge clk);
    check({tag, ".d"},        d,        ed);
    check({tag, ".d_valid"},  d_valid,  ev);
    check({tag, ".busy"},     busy,     ev);
    check({tag, ".first"},    first,    ef);
    check({tag, ".last"},     last,     el);
    check({tag, ".in_ready"}, in_ready, er);
  endtask

  task automatic step_l(input string tag, input logic ed, input logic ev,
                        input logic ef, input logic el, input logic er);
    @(negedge clk);
    check({tag, ".d"},        d_l,        ed);
    check({tag, ".d_valid"},  d_valid_l,  ev);
    check({tag, ".busy"},     busy_l,     ev);
    check({tag, ".first"},    first_l,    ef);
    check({tag, ".last"},     last_l,     el);
    check({tag, ".in_ready"}, in_ready_l, er);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst        = 1'b1;
    par_in     = 4'b0000;
    in_valid   = 1'b0;
    par_in_l   = 4'b0000;
    in_valid_l = 1'b0;

    #2;
    check("rst.d_valid",  d_valid,  1'b0);
    check("rst.d",        d,        1'b0);
    check("rst.busy",     busy,     1'b0);
    check("rst.first",    first,    1'b0);
    check("rst.last",     last,     1'b0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.lsb_rdy",  in_ready_l, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Single word, MSB first: 1011 -> 1,0,1,1
    step("w1.idle", 0, 0, 0, 0, 1);
    par_in = 4'b1011; in_valid = 1'b1;
    $display("txn: msb word 1011");
    step("w1.b1", 1, 1, 1, 0, 0);
    in_valid = 1'b0;
    step("w1.b2", 0, 1, 0, 0, 0);
    step("w1.b3", 1, 1, 0, 0, 0);
    step("w1.b4", 1, 1, 0, 1, 1);
    step("w1.end", 0, 0, 0, 0, 1);

    // Back-to-back 1011 then 0110; second word presented while busy.
    par_in = 4'b1011; in_valid = 1'b1;
    $display("txn: back-to-back 1011,0110");
    step("bb.b1", 1, 1, 1, 0, 0);
    par_in = 4'b0110;
    step("bb.b2", 0, 1, 0, 0, 0);
    step("bb.b3", 1, 1, 0, 0, 0);
    step("bb.b4", 1, 1, 0, 1, 1);
    step("bb.b5", 0, 1, 1, 0, 0);
    in_valid = 1'b0;
    step("bb.b6", 1, 1, 0, 0, 0);
    step("bb.b7", 1, 1, 0, 0, 0);
    step("bb.b8", 0, 1, 0, 1, 1);
    step("bb.end", 0, 0, 0, 0, 1);

    // Reset after the second bit of 1101.
    par_in = 4'b1101; in_valid = 1'b1;
    $display("txn: abort word 1101 by reset");
    step("ab.b1", 1, 1, 1, 0, 0);
    in_valid = 1'b0;
    step("ab.b2", 1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("ab.rst.d_valid",  d_valid,  1'b0);
    check("ab.rst.d",        d,        1'b0);
    check("ab.rst.busy",     busy,     1'b0);
    check("ab.rst.first",    first,    1'b0);
    check("ab.rst.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("ab.post1", 0, 0, 0, 0, 1);
    step("ab.post2", 0, 0, 0, 0, 1);
    step("ab.post3", 0, 0, 0, 0, 1);

    // LSB first: 1011 -> 1,1,0,1
    par_in_l = 4'b1011; in_valid_l = 1'b1;
    $display("txn: lsb word 1011");
    step_l("lsb.b1", 1, 1, 1, 0, 0);
    in_valid_l = 1'b0;
    step_l("lsb.b2", 1, 1, 0, 0, 0);
    step_l("lsb.b3", 0, 1, 0, 0, 0);
    step_l("lsb.b4", 1, 1, 0, 1, 1);
    step_l("lsb.end", 0, 0, 0, 0, 1);

    // Into the SIPO: 1001 lands intact.
    par_in = 4'b1001; in_valid = 1'b1;
    $display("txn: sipo word 1001");
    step("sp.b1", 1, 1, 1, 0, 0);
    in_valid = 1'b0;
    step("sp.b2", 0, 1, 0, 0, 0);
    step("sp.b3", 0, 1, 0, 0, 0);
    step("sp.b4", 1, 1, 0, 1, 1);
    step("sp.end", 0, 0, 0, 0, 1);
    check("sp.sipo_q", sipo_q, 4'b1001);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
